// File: rtl/sdram_req_queue.sv
// Host request FIFO feeding sdram_controller one command at a time, holding each until granted.
// Read data comes back to the host as a one-cycle strobe; a read that never returns data yields an error strobe.
module sdram_req_queue #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   host_we,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      host_wdata,
  output logic                   resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_err,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   rd_req,
  output logic                   wr_req,
  output logic [ADDR_W-1:0]      in_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [1:0]             bank_addr,
  input  logic                   rd_gnt,
  input  logic                   wr_gnt,
  input  logic                   rd_data_valid,
  input  logic [DATA_W-1:0]      rd_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam logic [PW:0]   FULL_LVL = (PW+1)'(DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {Q_IDLE, Q_ISSUE, Q_WAIT_DATA} state_t;

  state_t              state_q, state_d;
  logic [EW-1:0]       mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                ready_en;
  logic                push, pop;
  logic [EW-1:0]       head;
  logic [TW-1:0]       timer_q, timer_d;
  logic                rd_req_d, wr_req_d, resp_valid_d, resp_err_d;
  logic [ADDR_W-1:0]   in_addr_d;
  logic [DATA_W-1:0]   wr_data_d, resp_data_d;

  // ready_en keeps host_ready low until the first clock after reset release
  assign host_ready = ready_en && (level < FULL_LVL);
  assign push       = host_valid && host_ready;
  assign head       = mem[rd_ptr];
  assign bank_addr  = in_addr[ADDR_W-1 -: 2];
  assign busy       = (level != '0) || (state_q != Q_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {host_we, host_addr, host_wdata};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // The head entry stays in the FIFO until its grant, so level counts the in-flight command
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    rd_req_d     = rd_req;
    wr_req_d     = wr_req;
    in_addr_d    = in_addr;
    wr_data_d    = wr_data;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = '0;
    pop          = 1'b0;
    case (state_q)
      Q_IDLE: begin
        if (level != '0) begin
          in_addr_d = head[ADDR_W+DATA_W-1:DATA_W];
          wr_data_d = head[DATA_W-1:0];
          wr_req_d  = head[EW-1];
          rd_req_d  = !head[EW-1];
          state_d   = Q_ISSUE;
        end
      end
      Q_ISSUE: begin
        if (wr_req && wr_gnt) begin
          wr_req_d = 1'b0;
          pop      = 1'b1;
          state_d  = Q_IDLE;
        end else if (rd_req && rd_gnt) begin
          rd_req_d = 1'b0;
          pop      = 1'b1;
          timer_d  = '0;
          state_d  = Q_WAIT_DATA;
        end
      end
      Q_WAIT_DATA: begin
        if (rd_data_valid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = rd_data;
          state_d      = Q_IDLE;
        end else if (timer_q == T_LAST) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = Q_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = Q_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= Q_IDLE;
      timer_q    <= '0;
      rd_req     <= 1'b0;
      wr_req     <= 1'b0;
      in_addr    <= '0;
      wr_data    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rd_req     <= rd_req_d;
      wr_req     <= wr_req_d;
      in_addr    <= in_addr_d;
      wr_data    <= wr_data_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_data  <= resp_data_d;
    end
  end
endmodule

// File: tb/tb_sdram_req_queue.sv
// Randomized scenario bench for sdram_req_queue; a request queue model supplies issue order,
// and response timing is derived arithmetically from grant and data-return cycles.
module tb_sdram_req_queue;
  localparam int ADDR_W = 24, DATA_W = 8, DEPTH = 4, RD_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_;
  logic host_valid, host_ready, host_we;
  logic [ADDR_W-1:0] host_addr, in_addr;
  logic [DATA_W-1:0] host_wdata, resp_data, wr_data, rd_data;
  logic resp_valid, resp_err, busy, rd_req, wr_req, rd_gnt, wr_gnt, rd_data_valid;
  logic [2:0] level;
  logic [1:0] bank_addr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;
  req_t mq[$];

  sdram_req_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .reset_(reset_), .host_valid(host_valid), .host_ready(host_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .level(level), .busy(busy), .rd_req(rd_req), .wr_req(wr_req), .in_addr(in_addr),
    .wr_data(wr_data), .bank_addr(bank_addr), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({rd_req, wr_req, resp_valid, resp_err, busy, host_ready} !== 6'b0) begin failures++; $display("FAIL reset_ctl: got=%b exp=000000", {rd_req, wr_req, resp_valid, resp_err, busy, host_ready}); end
    checks++; if ({resp_data, in_addr, wr_data, bank_addr, level} !== '0) begin failures++; $display("FAIL reset_data: got=%0h exp=0", {resp_data, in_addr, wr_data, bank_addr, level}); end
    reset_ = 1'b1;
    #1;
    checks++; if (host_ready !== 1'b0) begin failures++; $display("FAIL ready_before_clk: got=%b exp=0", host_ready); end
    cyc();
    checks++; if ({host_ready, level, busy} !== {1'b1, 3'd0, 1'b0}) begin failures++; $display("FAIL ready_after_clk: got=%b exp=10000", {host_ready, level, busy}); end
  endtask

  task automatic test_write();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int g;
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 24'hC00123 : ADDR_W'($urandom);
      d = (k == 0) ? 8'h5A : DATA_W'($urandom);
      g = (k == 0) ? 3 : int'($urandom_range(1, 5));
      host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      cyc();
      host_valid = 1'b0;
      checks++; if ({level, wr_req} !== {3'd1, 1'b0}) begin failures++; $display("FAIL wr_push: got=%0h exp=%0h", {level, wr_req}, {3'd1, 1'b0}); end
      cyc();
      checks++; if ({wr_req, rd_req, bank_addr, in_addr, wr_data} !== {1'b1, 1'b0, a[23:22], a, d}) begin failures++; $display("FAIL wr_issue: got=%0h exp=%0h", {wr_req, rd_req, bank_addr, in_addr, wr_data}, {1'b1, 1'b0, a[23:22], a, d}); end
      for (int i = 1; i < g; i++) begin
        cyc();
        checks++; if ({wr_req, in_addr, wr_data, resp_valid} !== {1'b1, a, d, 1'b0}) begin failures++; $display("FAIL wr_hold: got=%0h exp=%0h", {wr_req, in_addr, wr_data, resp_valid}, {1'b1, a, d, 1'b0}); end
      end
      wr_gnt = 1'b1;
      cyc();
      wr_gnt = 1'b0;
      checks++; if ({wr_req, level, busy, resp_valid} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL wr_grant: got=%0h exp=0", {wr_req, level, busy, resp_valid}); end
    end
  endtask

  task automatic test_read();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v, ev;
    logic eerr;
    int g, dd, e;
    for (int k = 0; k < 8; k++) begin
      a  = (k == 0) ? 24'h000400 : ADDR_W'($urandom);
      v  = (k == 0) ? 8'hA7 : DATA_W'($urandom_range(1, 255));
      g  = (k == 0) ? 2 : int'($urandom_range(1, 4));
      dd = (k == 0) ? 2 : (k == 1) ? RD_TIMEOUT : (k == 2) ? RD_TIMEOUT + 3 : int'($urandom_range(1, RD_TIMEOUT + 4));
      e    = (dd <= RD_TIMEOUT) ? dd : RD_TIMEOUT;
      eerr = (dd > RD_TIMEOUT);
      ev   = eerr ? '0 : v;
      host_valid = 1'b1; host_we = 1'b0; host_addr = a; host_wdata = DATA_W'($urandom);
      cyc();
      host_valid = 1'b0;
      cyc();
      checks++; if ({rd_req, wr_req, bank_addr, in_addr} !== {1'b1, 1'b0, a[23:22], a}) begin failures++; $display("FAIL rd_issue: got=%0h exp=%0h", {rd_req, wr_req, bank_addr, in_addr}, {1'b1, 1'b0, a[23:22], a}); end
      repeat (g - 1) cyc();
      rd_gnt = 1'b1;
      cyc();
      rd_gnt = 1'b0;
      checks++; if ({rd_req, level, busy} !== {1'b0, 3'd0, 1'b1}) begin failures++; $display("FAIL rd_grant: got=%0h exp=1", {rd_req, level, busy}); end
      for (int i = 1; i < e; i++) begin
        cyc();
        checks++; if ({resp_valid, resp_err} !== 2'b00) begin failures++; $display("FAIL rd_early_resp: got=%b exp=00 cycle=%0d", {resp_valid, resp_err}, i); end
      end
      rd_data = v;
      rd_data_valid = !eerr;
      cyc();
      rd_data_valid = 1'b0;
      checks++; if ({resp_valid, resp_err, resp_data} !== {1'b1, eerr, ev}) begin failures++; $display("FAIL rd_resp: got=%0h exp=%0h dd=%0d", {resp_valid, resp_err, resp_data}, {1'b1, eerr, ev}, dd); end
      cyc();
      checks++; if ({resp_valid, resp_err, busy} !== 3'b000) begin failures++; $display("FAIL rd_resp_pulse: got=%b exp=000", {resp_valid, resp_err, busy}); end
    end
  endtask

  task automatic test_back_to_back();
    req_t ent[5];
    req_t h;
    int n;
    for (int k = 0; k < 5; k++) begin
      ent[k].we = 1'b1; ent[k].addr = ADDR_W'($urandom); ent[k].data = DATA_W'($urandom);
    end
    mq.delete();
    for (int k = 0; k < 4; k++) begin
      host_valid = 1'b1; host_we = 1'b1; host_addr = ent[k].addr; host_wdata = ent[k].data;
      checks++; if (host_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL fill_ready: got=%b exp=1 push=%0d", host_ready, k); end
      cyc();
      mq.push_back(ent[k]);
    end
    host_addr = ent[4].addr; host_wdata = ent[4].data;
    checks++; if ({host_ready, level} !== {1'b0, 3'(mq.size())}) begin failures++; $display("FAIL full: got=%0h exp=%0h", {host_ready, level}, {1'b0, 3'(mq.size())}); end
    repeat (2) begin
      cyc();
      checks++; if ({host_ready, level, wr_req, in_addr} !== {1'b0, 3'd4, 1'b1, ent[0].addr}) begin failures++; $display("FAIL full_stall: got=%0h exp=%0h", {host_ready, level, wr_req, in_addr}, {1'b0, 3'd4, 1'b1, ent[0].addr}); end
    end
    wr_gnt = 1'b1;
    cyc();
    wr_gnt = 1'b0;
    void'(mq.pop_front());
    checks++; if ({host_ready, level, wr_req} !== {1'b1, 3'(mq.size()), 1'b0}) begin failures++; $display("FAIL full_pop: got=%0h exp=%0h", {host_ready, level, wr_req}, {1'b1, 3'(mq.size()), 1'b0}); end
    cyc();
    host_valid = 1'b0;
    mq.push_back(ent[4]);
    checks++; if (level !== 3'(mq.size())) begin failures++; $display("FAIL late_push: got=%0d exp=%0d", level, mq.size()); end
    while (mq.size() > 0) begin
      n = 0;
      while (wr_req !== 1'b1 && n < 8) begin cyc(); n++; end
      h = mq.pop_front();
      checks++; if ({wr_req, rd_req, in_addr, wr_data} !== {1'b1, 1'b0, h.addr, h.data}) begin failures++; $display("FAIL drain_order: got=%0h exp=%0h", {wr_req, rd_req, in_addr, wr_data}, {1'b1, 1'b0, h.addr, h.data}); end
      repeat ($urandom_range(0, 2)) cyc();
      wr_gnt = 1'b1;
      cyc();
      wr_gnt = 1'b0;
      checks++; if ({wr_req, rd_req, level} !== {1'b0, 1'b0, 3'(mq.size())}) begin failures++; $display("FAIL drain_gap: got=%0h exp=%0h", {wr_req, rd_req, level}, {2'b00, 3'(mq.size())}); end
    end
  endtask

  task automatic test_timeout();
    req_t r, w;
    r.we = 1'b0; r.addr = ADDR_W'($urandom); r.data = '0;
    w.we = 1'b1; w.addr = ADDR_W'($urandom); w.data = DATA_W'($urandom);
    host_valid = 1'b1; host_we = r.we; host_addr = r.addr; host_wdata = r.data;
    cyc();
    host_we = w.we; host_addr = w.addr; host_wdata = w.data;
    cyc();
    host_valid = 1'b0;
    rd_data = DATA_W'($urandom_range(1, 255));
    checks++; if ({rd_req, level, in_addr} !== {1'b1, 3'd2, r.addr}) begin failures++; $display("FAIL to_issue: got=%0h exp=%0h", {rd_req, level, in_addr}, {1'b1, 3'd2, r.addr}); end
    repeat ($urandom_range(0, 3)) cyc();
    rd_gnt = 1'b1;
    cyc();
    rd_gnt = 1'b0;
    checks++; if ({rd_req, wr_req, level} !== {1'b0, 1'b0, 3'd1}) begin failures++; $display("FAIL to_grant: got=%0h exp=1", {rd_req, wr_req, level}); end
    for (int i = 1; i < RD_TIMEOUT; i++) begin
      cyc();
      checks++; if ({resp_valid, wr_req} !== 2'b00) begin failures++; $display("FAIL to_early: got=%b exp=00 cycle=%0d", {resp_valid, wr_req}, i); end
    end
    cyc();
    checks++; if ({resp_valid, resp_err, resp_data} !== {1'b1, 1'b1, 8'h00}) begin failures++; $display("FAIL to_resp: got=%0h exp=%0h", {resp_valid, resp_err, resp_data}, {2'b11, 8'h00}); end
    cyc();
    checks++; if ({resp_valid, resp_err, wr_req, in_addr, wr_data} !== {1'b0, 1'b0, 1'b1, w.addr, w.data}) begin failures++; $display("FAIL to_next_issue: got=%0h exp=%0h", {resp_valid, resp_err, wr_req, in_addr, wr_data}, {2'b00, 1'b1, w.addr, w.data}); end
    wr_gnt = 1'b1;
    cyc();
    wr_gnt = 1'b0;
    checks++; if ({wr_req, level, busy} !== 5'b0) begin failures++; $display("FAIL to_drain: got=%0h exp=0", {wr_req, level, busy}); end
  endtask

  task automatic test_stray();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    a = ADDR_W'($urandom);
    v = DATA_W'($urandom);
    host_valid = 1'b1; host_we = 1'b0; host_addr = a;
    cyc();
    host_valid = 1'b0;
    cyc();
    wr_gnt = 1'b1; rd_data_valid = 1'b1; rd_data = ~v;
    repeat (3) begin
      cyc();
      checks++; if ({rd_req, wr_req, level, resp_valid, in_addr} !== {1'b1, 1'b0, 3'd1, 1'b0, a}) begin failures++; $display("FAIL stray_issue: got=%0h exp=%0h", {rd_req, wr_req, level, resp_valid, in_addr}, {2'b10, 3'd1, 1'b0, a}); end
    end
    rd_data_valid = 1'b0; wr_gnt = 1'b0; rd_gnt = 1'b1;
    cyc();
    rd_gnt = 1'b0; wr_gnt = 1'b1;
    repeat (2) begin
      cyc();
      checks++; if ({resp_valid, rd_req, level, busy} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin failures++; $display("FAIL stray_wait: got=%0h exp=1", {resp_valid, rd_req, level, busy}); end
    end
    wr_gnt = 1'b0; rd_data_valid = 1'b1; rd_data = v;
    cyc();
    rd_data_valid = 1'b0;
    checks++; if ({resp_valid, resp_err, resp_data} !== {2'b10, v}) begin failures++; $display("FAIL stray_resp: got=%0h exp=%0h", {resp_valid, resp_err, resp_data}, {2'b10, v}); end
    cyc();
    rd_data_valid = 1'b1; rd_data = DATA_W'($urandom);
    repeat (4) begin
      cyc();
      checks++; if ({resp_valid, rd_req, wr_req, level, busy} !== 7'b0) begin failures++; $display("FAIL stray_idle: got=%0h exp=0", {resp_valid, rd_req, wr_req, level, busy}); end
    end
    rd_data_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    host_valid = 1'b1; host_we = 1'b0; host_addr = ADDR_W'($urandom);
    cyc();
    host_we = 1'b1; host_addr = ADDR_W'($urandom); host_wdata = DATA_W'($urandom);
    cyc();
    host_addr = ADDR_W'($urandom); host_wdata = DATA_W'($urandom);
    cyc();
    host_valid = 1'b0;
    rd_gnt = 1'b1;
    cyc();
    rd_gnt = 1'b0;
    checks++; if ({level, busy, rd_req} !== {3'd2, 1'b1, 1'b0}) begin failures++; $display("FAIL rm_pending: got=%0h exp=%0h", {level, busy, rd_req}, {3'd2, 2'b10}); end
    repeat (3) cyc();
    #2;
    reset_ = 1'b0;
    #1;
    checks++; if ({rd_req, wr_req, resp_valid, resp_err, busy, host_ready} !== 6'b0) begin failures++; $display("FAIL rm_ctl: got=%b exp=000000", {rd_req, wr_req, resp_valid, resp_err, busy, host_ready}); end
    checks++; if ({resp_data, in_addr, wr_data, bank_addr, level} !== '0) begin failures++; $display("FAIL rm_data: got=%0h exp=0", {resp_data, in_addr, wr_data, bank_addr, level}); end
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
    cyc();
    checks++; if ({host_ready, level} !== {1'b1, 3'd0}) begin failures++; $display("FAIL rm_release: got=%0h exp=8", {host_ready, level}); end
    for (int i = 0; i < 20; i++) begin
      rd_data_valid = 1'($urandom_range(0, 1));
      cyc();
      checks++; if ({resp_valid, rd_req, wr_req, level} !== 6'b0) begin failures++; $display("FAIL rm_quiet: got=%0h exp=0 cycle=%0d", {resp_valid, rd_req, wr_req, level}, i); end
    end
    rd_data_valid = 1'b0;
    a = ADDR_W'($urandom); d = DATA_W'($urandom);
    host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    cyc();
    host_valid = 1'b0;
    cyc();
    checks++; if ({wr_req, in_addr, wr_data} !== {1'b1, a, d}) begin failures++; $display("FAIL rm_new_issue: got=%0h exp=%0h", {wr_req, in_addr, wr_data}, {1'b1, a, d}); end
    wr_gnt = 1'b1;
    cyc();
    wr_gnt = 1'b0;
    checks++; if ({wr_req, level, busy} !== 5'b0) begin failures++; $display("FAIL rm_new_done: got=%0h exp=0", {wr_req, level, busy}); end
  endtask

  initial begin
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    rd_gnt = 1'b0; wr_gnt = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_stray();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
